vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-clock arbiter sharing one port of the 32 KiB video/work RAM between the 6502 CPU and the PPU character fetcher. It drives the RAM address/data/write-enable from whichever requester holds the grant, stalls the CPU through its RDY input when the PPU wins, and returns read data with a registered valid strobe. PPU has priority by default; a starvation counter guarantees CPU progress.

## Interface
- `ADDR_W`, 15: RAM word-address width.
- `DATA_W`, 8: data width.
- `MAX_CPU_WAIT`, 4: consecutive denied CPU cycles before a forced CPU grant; legal range 1..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `cpu_req`  in  1  CPU access request, held until granted.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdy`  out  1  to 6502 RDY; 0 stalls the CPU.
- `cpu_rdata`  out  DATA_W  read data, valid with `cpu_rvalid`.
- `cpu_rvalid`  out  1  one-cycle read-return strobe.
- `ppu_req`  in  1  PPU read request (PPU never writes).
- `ppu_addr`  in  ADDR_W  PPU address.
- `ppu_gnt`  out  1  PPU request accepted this cycle.
- `ppu_rdata`  out  DATA_W  read data, valid with `ppu_rvalid`.
- `ppu_rvalid`  out  1  one-cycle read-return strobe.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_we`  out  1  RAM write enable.
- `mem_q`  in  DATA_W  RAM registered read data (1-cycle latency).

## Operation
- At most one grant per cycle; grant decision combinational from requests, FSM state, starvation count.
- FSM states: `ARB_NORMAL`, `ARB_FORCE_CPU`.
  - `ARB_NORMAL`: `ppu_req` → PPU granted; else `cpu_req` → CPU granted; else idle.
  - `ARB_FORCE_CPU`: CPU granted unconditionally if `cpu_req`; PPU denied (`ppu_gnt`=0, PPU keeps requesting).
  - NORMAL → FORCE_CPU when `cpu_req`, CPU denied, and `starve_cnt == MAX_CPU_WAIT-1`.
  - FORCE_CPU → NORMAL after the CPU grant cycle, or if `cpu_req` drops.
- `starve_cnt` (4 bit): +1 per cycle CPU requests and is denied; cleared on CPU grant or `cpu_req`=0; saturates at 15.
- `cpu_rdy = ~cpu_req | cpu_gnt` (combinational).
- Mux: grant CPU → `mem_addr=cpu_addr`, `mem_we=cpu_we`, `mem_wdata=cpu_wdata`; grant PPU → `mem_addr=ppu_addr`, `mem_we=0`; idle → `mem_addr` holds last value, `mem_we=0`.
- Return tag register `rtag` ∈ {NONE, CPU, PPU} loaded on every cycle: CPU if CPU read granted, PPU if PPU granted, else NONE. CPU writes load NONE.
- `cpu_rvalid = (rtag==CPU)`, `ppu_rvalid = (rtag==PPU)`; `cpu_rdata = ppu_rdata = mem_q`.

## Timing
- Grant at cycle N → RAM access at edge ending N → `*_rvalid`/data during N+1. Read latency 1 cycle from grant.
- Back-to-back grants to either requester sustained at 1 per cycle; CPU write then read to same address returns written data.
- Worst-case CPU wait with continuous `ppu_req`: `MAX_CPU_WAIT` stall cycles, grant on following cycle.
- Reset (async assert): state=`ARB_NORMAL`, `starve_cnt`=0, `rtag`=NONE, `mem_addr` register=0; outputs while `reset`=1: `ppu_gnt`=0, `mem_we`=0, `cpu_rvalid`=`ppu_rvalid`=0, `cpu_rdy`=~`cpu_req`. Grants suppressed during reset.
- Reset mid-read: pending rvalid dropped, never emitted after release.
- Simultaneous requests in NORMAL with count below threshold: PPU wins, count increments.
- `cpu_req` dropping while stalled: no grant, count cleared, no rvalid.

## Structure
- Package `vram_arb_pkg`: `arb_state_e` (`ARB_NORMAL`, `ARB_FORCE_CPU`), `rtag_e` (`RTAG_NONE`, `RTAG_CPU`, `RTAG_PPU`), `STARVE_W`=4.
- Single module; no sub-module needed. Top-level instantiates it between `cpu6502`, `ppu_char` and the RAM port A.

## Test plan
- CPU alone: write 0x5A to 0x0100, read 0x0100 → `cpu_rdy` stays 1, `cpu_rvalid` next cycle with `cpu_rdata`=0x5A, `ppu_gnt`=0 throughout.
- PPU alone, addresses 0x1000..0x1007 back-to-back → 8 `ppu_gnt` in 8 cycles, 8 `ppu_rvalid` one cycle later, data matches preload.
- Both continuous, `MAX_CPU_WAIT`=4 → pattern 4 PPU grants, 1 CPU grant, repeating; `cpu_rdy` low exactly 4 cycles per CPU access.
- CPU write 0x33 to 0x2000 while PPU reads 0x2000 every cycle → `mem_we`=1 only in CPU grant cycle; PPU read after it returns 0x33.
- `reset` asserted the cycle after a PPU read grant → `ppu_rvalid` stays 0; after release state NORMAL, `starve_cnt`=0.
- CPU requests, denied twice, drops `cpu_req` → no CPU grant, no `cpu_rvalid`, next CPU request starts count from 0.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM port arbiter: arbitration FSM states, read-return tags,
// and the width of the starvation counter.
package vram_arb_pkg;

    localparam int unsigned STARVE_W = 4;

    typedef enum logic {
        ARB_NORMAL,
        ARB_FORCE_CPU
    } arb_state_e;

    typedef enum logic [1:0] {
        RTAG_NONE,
        RTAG_CPU,
        RTAG_PPU
    } rtag_e;

    localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of CPU, PPU and RAM-port signals around the VRAM arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the RAM.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_rdy;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_gnt;
    logic [DATA_W-1:0] ppu_rdata;
    logic              ppu_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ppu_req, ppu_addr,
        input  mem_q,
        output cpu_rdy, cpu_rdata, cpu_rvalid,
        output ppu_gnt, ppu_rdata, ppu_rvalid,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ppu_req, ppu_addr,
        output mem_q,
        input  cpu_rdy, cpu_rdata, cpu_rvalid,
        input  ppu_gnt, ppu_rdata, ppu_rvalid,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/vram_arbiter.sv
// Shares one VRAM port between the 6502 and the PPU character fetcher: PPU wins by default,
// a starvation counter forces a CPU grant after MAX_CPU_WAIT consecutive denials.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_CPU_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_CPU_WAIT - 1);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    rtag_e               rtag_q;
    rtag_e               rtag_d;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   rdata;
    logic                cpu_gnt;
    logic                ppu_gnt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_NORMAL: begin
                if (bus.cpu_req && !cpu_gnt && (starve_q == STARVE_LIMIT)) begin
                    state_d = ARB_FORCE_CPU;
                end
            end
            ARB_FORCE_CPU: begin
                if (cpu_gnt || !bus.cpu_req) begin
                    state_d = ARB_NORMAL;
                end
            end
            default: state_d = ARB_NORMAL;
        endcase
    end

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        cpu_gnt = 1'b0;
        ppu_gnt = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ARB_NORMAL: begin
                    ppu_gnt = bus.ppu_req;
                    cpu_gnt = bus.cpu_req && !bus.ppu_req;
                end
                ARB_FORCE_CPU: begin
                    cpu_gnt = bus.cpu_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    ppu_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.cpu_req || cpu_gnt) begin
            starve_d = '0;
        end else if (starve_q != STARVE_SAT) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        if (cpu_gnt) begin
            mem_addr_d = bus.cpu_addr;
        end else if (ppu_gnt) begin
            mem_addr_d = bus.ppu_addr;
        end
    end

    always_comb begin
        rtag_d = RTAG_NONE;
        if (cpu_gnt && !bus.cpu_we) begin
            rtag_d = RTAG_CPU;
        end else if (ppu_gnt) begin
            rtag_d = RTAG_PPU;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q   <= '0;
            rtag_q     <= RTAG_NONE;
            mem_addr_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rtag_q     <= rtag_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Output logic; the address register only supplies the idle-cycle address
    always_comb begin
        rdata          = bus.mem_q;
        bus.mem_addr   = mem_addr_d;
        bus.mem_we     = cpu_gnt && bus.cpu_we;
        bus.mem_wdata  = cpu_gnt ? bus.cpu_wdata : '0;
        bus.cpu_rdy    = !bus.cpu_req || cpu_gnt;
        bus.ppu_gnt    = ppu_gnt;
        bus.cpu_rvalid = (rtag_q == RTAG_CPU);
        bus.ppu_rvalid = (rtag_q == RTAG_PPU);
        bus.cpu_rdata  = rdata;
        bus.ppu_rdata  = rdata;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic, checked
// against a cycle-level behavioural model of grants, stalls and read returns.
module tb_vram_arbiter;

    localparam int unsigned AW   = 15;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXW = 4;
    localparam int unsigned MEMN = 32768;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_CPU_WAIT(MAXW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] preload(input int a);
        return DW'(a * 7 + (a >>> 8) + 3);
    endfunction

    // RAM port with registered read data; contents preloaded on the first edge
    logic [DW-1:0] ram [MEMN];
    bit            ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < int'(MEMN); i++) ram[i] = preload(i);
            ram_loaded = 1'b1;
        end
        bus.mem_q <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
    end

    // Reference model: how many cycles the CPU has been waiting, which read returns next
    logic [DW-1:0] ref_mem [MEMN];
    int            wait_cnt;
    int            pend;        // 0 none, 1 cpu, 2 ppu
    logic [DW-1:0] pend_data;
    logic [AW-1:0] last_addr;
    int            vectors;
    int            miscompares;
    int            ppu_seen;
    int            cpu_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit cr, input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input bit pr, input logic [AW-1:0] pa);
        bit forced;
        bit gc;
        bit gp;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ppu_req   = pr;
        bus.ppu_addr  = pa;
        @(negedge clk);
        if (rst) begin
            gc        = 1'b0;
            gp        = 1'b0;
            pend      = 0;
            last_addr = '0;
        end else begin
            forced = (wait_cnt >= int'(MAXW));
            gp     = pr && !forced;
            gc     = cr && (forced || !pr);
        end
        chk("ppu_gnt", 32'(bus.ppu_gnt), 32'(gp));
        chk("cpu_rdy", 32'(bus.cpu_rdy), 32'(!cr || gc));
        chk("mem_we", 32'(bus.mem_we), 32'(gc && cw));
        chk("mem_addr", 32'(bus.mem_addr), 32'(gc ? ca : (gp ? pa : last_addr)));
        if (gc && cw) chk("mem_wdata", 32'(bus.mem_wdata), 32'(cd));
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(pend == 1));
        chk("ppu_rvalid", 32'(bus.ppu_rvalid), 32'(pend == 2));
        if (pend == 1) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(pend_data));
        if (pend == 2) chk("ppu_rdata", 32'(bus.ppu_rdata), 32'(pend_data));
        if (bus.ppu_gnt) ppu_seen++;
        if (cr && bus.cpu_rdy) cpu_seen++;

        if (rst) begin
            wait_cnt = 0;
        end else begin
            pend_data = gc ? ref_mem[ca] : ref_mem[pa];
            pend      = (gc && !cw) ? 1 : (gp ? 2 : 0);
            if (gc && cw) ref_mem[ca] = cd;
            if (gc) last_addr = ca;
            else if (gp) last_addr = pa;
            wait_cnt = (cr && !gc) ? wait_cnt + 1 : 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    int base_ppu;
    int base_cpu;

    initial begin
        for (int i = 0; i < int'(MEMN); i++) ref_mem[i] = preload(i);
        wait_cnt      = 0;
        pend          = 0;
        pend_data     = '0;
        last_addr     = '0;
        vectors       = 0;
        miscompares   = 0;
        ppu_seen      = 0;
        cpu_seen      = 0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.ppu_req   = 1'b0;
        bus.ppu_addr  = '0;

        // reset: grants suppressed, cpu_rdy follows ~cpu_req
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 15'h0123, '0, 1'b1, 15'h0456);

        // CPU alone: write then read back
        base_ppu = ppu_seen;
        step(1'b0, 1'b1, 1'b1, 15'h0100, 8'h5A, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 15'h0100, '0, 1'b0, '0);
        idle();
        chk("cpu_alone_ppu_gnts", 32'(ppu_seen - base_ppu), 32'd0);

        // PPU alone, back-to-back reads
        base_ppu = ppu_seen;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(16'h1000 + i));
        idle();
        chk("ppu_burst_gnts", 32'(ppu_seen - base_ppu), 32'd8);

        // both requesting continuously: 4 PPU grants then 1 CPU grant
        base_ppu = ppu_seen;
        base_cpu = cpu_seen;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, AW'(16'h0100 + i / 5), '0, 1'b1, AW'(16'h1000 + i));
        chk("contention_cpu_gnts", 32'(cpu_seen - base_cpu), 32'd4);
        chk("contention_ppu_gnts", 32'(ppu_seen - base_ppu), 32'd16);

        // CPU write lands between PPU reads of the same address
        for (int i = 0; i < 10; i++) step(1'b0, i < 5, 1'b1, 15'h2000, 8'h33, 1'b1, 15'h2000);
        idle();

        // reset right after a PPU read grant drops the pending return
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 15'h1003);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 15'h1004);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 15'h0100, '0, 1'b1, AW'(16'h1005 + i));
        idle();

        // CPU denied twice then withdraws; a new request counts from zero
        step(1'b0, 1'b1, 1'b0, 15'h0200, '0, 1'b1, 15'h1000);
        step(1'b0, 1'b1, 1'b0, 15'h0200, '0, 1'b1, 15'h1001);
        step(1'b0, 1'b0, 1'b0, 15'h0200, '0, 1'b1, 15'h1002);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 15'h0200, '0, 1'b1, AW'(16'h1003 + i));
        idle();

        // random traffic over a small address window so reads see earlier writes
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 1) == 1,
                 AW'(16'h3000 + $urandom_range(0, 7)),
                 DW'($urandom),
                 $urandom_range(0, 3) != 0,
                 AW'(16'h3000 + $urandom_range(0, 7)));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
